state_watcher: RTL and testbench

STATE_WATCHER -- requirements
Module: state_watcher

---
 rtl/state_watcher.sv | 59 +++++
 tb/tb_state_watcher.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/state_watcher.sv
// Watches received UART bytes while its own ID is the current state; the first
// byte that differs from the ID parks the unit until the next reset.
module state_watcher #(
  parameter logic [7:0] MODULE_ID = 8'h15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Rx_ready,
  input  logic [7:0] Rx_data,
  output logic [7:0] state,
  output logic       state_change,
  output logic       active
);

  typedef enum logic {
    ST_ACTIVE   = 1'b0,
    ST_INACTIVE = 1'b1
  } fsm_t;

  fsm_t       fsm_reg, fsm_next;
  logic [7:0] state_reg, state_next;
  logic       change_reg, change_next;
  logic       rx_ready_q;
  logic       accept;

  // Only a 0->1 transition of the strobe counts, so a long level yields one byte.
  assign accept = Rx_ready && !rx_ready_q && (fsm_reg == ST_ACTIVE);

  always_comb begin
    fsm_next    = fsm_reg;
    state_next  = state_reg;
    change_next = 1'b0;
    if (accept) begin
      state_next  = Rx_data;
      change_next = 1'b1;
      fsm_next    = (Rx_data == MODULE_ID) ? ST_ACTIVE : ST_INACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    // Edge history tracks the input even in reset, so a level held through
    // reset release is not mistaken for a new strobe.
    rx_ready_q <= Rx_ready;
    if (reset) begin
      fsm_reg    <= ST_ACTIVE;
      state_reg  <= MODULE_ID;
      change_reg <= 1'b0;
    end else begin
      fsm_reg    <= fsm_next;
      state_reg  <= state_next;
      change_reg <= change_next;
    end
  end

  assign state        = state_reg;
  assign state_change = change_reg;
  assign active       = (fsm_reg == ST_ACTIVE);

endmodule

// File: tb/tb_state_watcher.sv
// Directed bench for state_watcher: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_state_watcher;

  logic       clk;
  logic       reset;
  logic       Rx_ready;
  logic [7:0] Rx_data;
  logic [7:0] state;
  logic       state_change;
  logic       active;

  int checks = 0;
  int errors = 0;

  state_watcher #(.MODULE_ID(8'h15)) dut (
    .clk(clk),
    .reset(reset),
    .Rx_ready(Rx_ready),
    .Rx_data(Rx_data),
    .state(state),
    .state_change(state_change),
    .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp_state,
                       input logic exp_change, input logic exp_active);
    checks++;
    assert (state === exp_state && state_change === exp_change && active === exp_active)
    else begin
      errors++;
      $error("FAIL %s observed state=%h change=%b active=%b expected state=%h change=%b active=%b",
             tag, state, state_change, active, exp_state, exp_change, exp_active);
    end
    $display("check %s: state=%h change=%b active=%b", tag, state, state_change, active);
  endtask

  initial begin
    int pulses;
    reset    = 1'b1;
    Rx_ready = 1'b0;
    Rx_data  = 8'h00;
    tick();
    tick();
    check("reset", 8'h15, 1'b0, 1'b1);
    reset = 1'b0;
    tick();
    check("idle", 8'h15, 1'b0, 1'b1);

    // First byte differs from ID: accepted, unit goes inactive
    Rx_data = 8'hB6; Rx_ready = 1'b1;
    tick();
    check("accept_b6", 8'hB6, 1'b1, 1'b0);
    Rx_ready = 1'b0;
    tick();
    check("pulse_end_b6", 8'hB6, 1'b0, 1'b0);

    // Inactive ignores further strobes
    Rx_data = 8'hA7; Rx_ready = 1'b1;
    tick();
    check("ignore_a7", 8'hB6, 1'b0, 1'b0);
    Rx_ready = 1'b0;
    tick();
    check("ignore_a7_low", 8'hB6, 1'b0, 1'b0);

    reset = 1'b1;
    tick();
    check("reset_from_inactive", 8'h15, 1'b0, 1'b1);
    reset = 1'b0;
    Rx_data = 8'h7A; Rx_ready = 1'b1;
    tick();
    check("accept_7a", 8'h7A, 1'b1, 1'b0);
    Rx_ready = 1'b0;
    tick();
    check("pulse_end_7a", 8'h7A, 1'b0, 1'b0);

    // Byte equal to ID keeps the unit active and still pulses
    reset = 1'b1;
    tick();
    reset = 1'b0;
    Rx_data = 8'h15; Rx_ready = 1'b1;
    tick();
    check("accept_same_id", 8'h15, 1'b1, 1'b1);
    Rx_ready = 1'b0;
    tick();
    check("same_id_pulse_end", 8'h15, 1'b0, 1'b1);
    Rx_data = 8'h22; Rx_ready = 1'b1;
    tick();
    check("accept_22", 8'h22, 1'b1, 1'b0);
    Rx_ready = 1'b0;

    // Reset during a pulse cancels it
    Rx_data = 8'h15;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    Rx_data = 8'h33; Rx_ready = 1'b1;
    tick();
    check("accept_33", 8'h33, 1'b1, 1'b0);
    Rx_ready = 1'b0;
    reset = 1'b1;
    tick();
    check("reset_cancels_pulse", 8'h15, 1'b0, 1'b1);
    reset = 1'b0;
    tick();

    // Long level: exactly one acceptance, later data changes ignored
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      Rx_data = 8'h40 + 8'(i);
      Rx_ready = 1'b1;
      tick();
      if (state_change) pulses++;
      check("held_level", 8'h40, (i == 0) ? 1'b1 : 1'b0, 1'b0);
    end
    Rx_ready = 1'b0;
    tick();
    checks++;
    assert (pulses == 1) else begin
      errors++;
      $error("FAIL held_pulse_count observed %0d expected 1", pulses);
    end

    // Level held high through reset release is not an edge
    reset = 1'b1; Rx_ready = 1'b1; Rx_data = 8'h55;
    tick();
    check("reset_with_ready_high", 8'h15, 1'b0, 1'b1);
    reset = 1'b0;
    tick();
    check("held_through_release", 8'h15, 1'b0, 1'b1);
    tick();
    check("held_through_release2", 8'h15, 1'b0, 1'b1);
    Rx_ready = 1'b0;
    tick();
    Rx_ready = 1'b1;
    tick();
    check("accept_after_low", 8'h55, 1'b1, 1'b0);
    Rx_ready = 1'b0;

    // Reset wins over a simultaneous rising edge
    reset = 1'b1;
    tick();
    Rx_data = 8'h66; Rx_ready = 1'b1;
    tick();
    check("reset_priority", 8'h15, 1'b0, 1'b1);
    reset = 1'b0;
    tick();
    check("edge_consumed_in_reset", 8'h15, 1'b0, 1'b1);
    Rx_ready = 1'b0;
    tick();
    Rx_ready = 1'b1;
    tick();
    check("accept_66", 8'h66, 1'b1, 1'b0);
    Rx_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
